// File: rtl/init_axil_pkg.sv
// Package for the init_axil_regs AXI4-Lite register slave.
// Holds the response codes, the write/read FSM state types, the register
// map constants and the byte-strobe merge helper shared by the slave.
package init_axil_pkg;

    localparam int DATA_W    = 32;
    localparam int STRB_W    = DATA_W / 8;
    localparam int NUM_REGS  = 4;
    localparam int REG_IDX_W = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [7:0] REG0_OFFSET = 8'h00;
    localparam logic [7:0] REG1_OFFSET = 8'h04;
    localparam logic [7:0] REG2_OFFSET = 8'h08;
    localparam logic [7:0] REG3_OFFSET = 8'h0C;

    // Entry i is the byte offset of register i.
    localparam logic [NUM_REGS-1:0][7:0] REG_OFFSETS =
        {REG3_OFFSET, REG2_OFFSET, REG1_OFFSET, REG0_OFFSET};

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,   // waiting for AW and/or W
        W_ADDR = 2'b01,   // AW captured, W pending
        W_DATA = 2'b10,   // W captured, AW pending
        W_RESP = 2'b11    // write committed, B response presented
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,    // accepting AR
        R_DATA = 1'b1     // R response presented
    } r_state_e;

    // Replace byte lane k of old_v with the same lane of new_v where strb[k] is set.
    function automatic logic [DATA_W-1:0] strb_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int k = 0; k < STRB_W; k++) begin
            res[8*k +: 8] = strb[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/init_axil_regs.sv
// init_axil_regs: AXI4-Lite slave with four 32-bit read/write registers.
//
// Ports:
//   ACLK, ARESET            clock, asynchronous active-high reset
//   S_AXI_AW*               write address channel (AWPROT ignored)
//   S_AXI_W*                write data channel with byte strobes
//   S_AXI_B*                write response channel
//   S_AXI_AR*               read address channel (ARPROT ignored)
//   S_AXI_R*                read data channel
//   REG_OUT                 {reg3, reg2, reg1, reg0}, reg0 in bits [31:0]
//
// Registers sit at byte offsets 0x00..0x0C; ADDR[1:0] are ignored. Any other
// address answers SLVERR, reads return zero and writes are dropped.
// The write and read paths are independent FSMs; every output is a flop.
module init_axil_regs
    import init_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] REG_OUT
);

    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int WORD_W = AW - 2;

    // One-hot register select for a word address; all-zero means out of range.
    function automatic logic [NUM_REGS-1:0] reg_decode(input logic [WORD_W-1:0] word);
        logic [NUM_REGS-1:0] hit;
        logic [AW-1:0]       byte_addr;
        byte_addr = {word, 2'b00};
        for (int i = 0; i < NUM_REGS; i++) begin
            hit[i] = (byte_addr == AW'(REG_OFFSETS[i]));
        end
        return hit;
    endfunction

    // Write path state
    w_state_e                  w_state_q, w_state_d;
    logic [WORD_W-1:0]         awaddr_q, awaddr_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;
    logic [STRB_W-1:0]         wstrb_q, wstrb_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [DATA_W-1:0]         regs_q [NUM_REGS];
    logic [DATA_W-1:0]         regs_d [NUM_REGS];

    // Read path state
    r_state_e                  r_state_q, r_state_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic [DATA_W-1:0]         rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;

    // Handshakes and commit operands
    logic                      aw_hs_s, w_hs_s, ar_hs_s;
    logic                      commit_s;
    logic [WORD_W-1:0]         cmt_word_s;
    logic [DATA_W-1:0]         cmt_data_s;
    logic [STRB_W-1:0]         cmt_strb_s;
    logic [NUM_REGS-1:0]       cmt_hit_s;
    logic [NUM_REGS-1:0]       rd_hit_s;
    logic [DATA_W-1:0]         rd_data_s;
    logic                      unused_s;

    assign aw_hs_s = S_AXI_AWVALID & awready_q;
    assign w_hs_s  = S_AXI_WVALID  & wready_q;
    assign ar_hs_s = S_AXI_ARVALID & arready_q;

    // Protection bits and byte-offset address bits carry no meaning here.
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // A same-cycle handshake supplies its operand directly; otherwise the captured copy is used.
    assign cmt_word_s = aw_hs_s ? S_AXI_AWADDR[AW-1:2] : awaddr_q;
    assign cmt_data_s = w_hs_s  ? S_AXI_WDATA          : wdata_q;
    assign cmt_strb_s = w_hs_s  ? S_AXI_WSTRB          : wstrb_q;
    assign cmt_hit_s  = reg_decode(cmt_word_s);

    // Write FSM next state, operand capture, register commit and B response.
    always_comb begin
        w_state_d = w_state_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    w_state_d = W_RESP;
                end else if (aw_hs_s) begin
                    w_state_d = W_ADDR;
                end else if (w_hs_s) begin
                    w_state_d = W_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_ADDR: begin
                if (w_hs_s) begin
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_ADDR;
                end
            end
            W_DATA: begin
                if (aw_hs_s) begin
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase

        // Commit happens on the edge that enters W_RESP.
        commit_s = (w_state_q != W_RESP) && (w_state_d == W_RESP);

        if (aw_hs_s) begin
            awaddr_d = S_AXI_AWADDR[AW-1:2];
        end else begin
            awaddr_d = awaddr_q;
        end

        if (w_hs_s) begin
            wdata_d = S_AXI_WDATA;
            wstrb_d = S_AXI_WSTRB;
        end else begin
            wdata_d = wdata_q;
            wstrb_d = wstrb_q;
        end

        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = (commit_s && cmt_hit_s[i])
                      ? strb_merge(regs_q[i], cmt_data_s, cmt_strb_s)
                      : regs_q[i];
        end

        if (commit_s) begin
            bvalid_d = 1'b1;
            bresp_d  = (|cmt_hit_s) ? RESP_OKAY : RESP_SLVERR;
        end else if ((w_state_q == W_RESP) && (w_state_d == W_IDLE)) begin
            bvalid_d = 1'b0;
            bresp_d  = RESP_OKAY;
        end else begin
            bvalid_d = bvalid_q;
            bresp_d  = bresp_q;
        end

        // Ready flags are registered copies of the state the FSM is heading into.
        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_DATA);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_ADDR);
    end

    assign rd_hit_s = reg_decode(S_AXI_ARADDR[AW-1:2]);

    // Read data mux over the current (pre-commit) register contents.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data_s = rd_data_s | (rd_hit_s[i] ? regs_q[i] : {DATA_W{1'b0}});
        end
    end

    // Read FSM next state and R channel capture.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_data_s;
                    rresp_d   = (|rd_hit_s) ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                rvalid_d  = 1'b0;
            end
        endcase

        arready_d = (r_state_d == R_IDLE);
    end

    // State and output registers for both channels; reset clears everything.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= {WORD_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            wstrb_q   <= {STRB_W{1'b0}};
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DATA_W{1'b0}};
            rresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign REG_OUT       = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

endmodule

// File: tb/tb_init_axil_regs.sv
// Self-checking bench for init_axil_regs: directed scenarios plus a random
// read/write mix compared against a plain array model of the register map.
module tb_init_axil_regs;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [4:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] reg_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [4];

    init_axil_regs dut (
        .ACLK          (clk),
        .ARESET        (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .REG_OUT       (reg_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [127:0] model_vec();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    function automatic logic [1:0] exp_resp(input logic [4:0] a);
        return (a < 5'd16) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        int idx;
        idx = int'(a) / 4;
        return (a < 5'd16) ? model[idx] : 32'h0;
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a) / 4;
        if (a < 5'd16) begin
            for (int k = 0; k < 4; k++) begin
                if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
    endtask

    // ---------------- bus drivers (called at a falling edge) ----------------
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output bit ok);
        int  n;
        bit  aw_f, w_f;
        resp = 2'b11;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(negedge clk);
            n++;
            if (aw_f) awvalid = 1'b0;
            if (w_f)  wvalid  = 1'b0;
        end
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = bvalid && !awvalid && !wvalid;
        resp = bresp;
        @(negedge clk);
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output bit ok);
        int n;
        bit f;
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            f = arready;
            @(negedge clk);
            n++;
            if (f) arvalid = 1'b0;
        end
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = rvalid; d = rdata; resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rresp} !== 9'h000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000000000",
                     {awready, wready, bvalid, bresp, arready, rvalid, rresp});
        end
        checks++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        checks++;
        if (reg_out !== 128'h0) begin
            failures++; $display("FAIL reset_regout: got %h expected 0", reg_out);
        end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            failures++;
            $display("FAIL reset_release: got %b expected 11100", {awready, wready, arready, bvalid, rvalid});
        end
    endtask

    task automatic test_basic();
        logic [1:0]  r;
        logic [31:0] d;
        bit          ok;
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4 * i), 32'(i + 1), 4'hF, r, ok);
            model_write(5'(4 * i), 32'(i + 1), 4'hF);
            checks++;
            if (!ok || r !== 2'b00) begin
                failures++; $display("FAIL basic_bresp[%0d]: got ok=%0d resp=%b expected ok=1 resp=00", i, ok, r);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), d, r, ok);
            checks++;
            if (!ok || d !== 32'(i + 1) || r !== 2'b00) begin
                failures++;
                $display("FAIL basic_read[%0d]: got ok=%0d data=%h resp=%b expected data=%h resp=00",
                         i, ok, d, r, 32'(i + 1));
            end
        end
        checks++;
        if (reg_out !== 128'h00000004_00000003_00000002_00000001) begin
            failures++; $display("FAIL basic_regout: got %h expected 00000004000000030000000200000001", reg_out);
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  r;
        logic [31:0] d;
        bit          ok;
        axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, r, ok);
        model_write(5'h04, 32'hFFFF_FFFF, 4'hF);
        axi_write(5'h04, 32'h0000_0000, 4'b0101, r, ok);
        model_write(5'h04, 32'h0000_0000, 4'b0101);
        axi_read(5'h04, d, r, ok);
        checks++;
        if (!ok || d !== 32'hFF00_FF00 || r !== 2'b00) begin
            failures++; $display("FAIL strobe_0101: got data=%h resp=%b expected FF00FF00 00", d, r);
        end
        // Zero strobe: unaligned address, nothing changes, still OKAY
        axi_write(5'h07, 32'h1234_5678, 4'h0, r, ok);
        checks++;
        if (!ok || r !== 2'b00 || reg_out !== model_vec()) begin
            failures++;
            $display("FAIL strobe_zero: got resp=%b regout=%h expected 00 %h", r, reg_out, model_vec());
        end
    endtask

    task automatic test_skew();
        logic [1:0]  r;
        logic [31:0] d;
        bit          ok;
        // AW leads W by three cycles
        bready = 1'b0;
        awaddr = 5'h08; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        checks++;
        if ({awready, wready} !== 2'b01) begin
            failures++; $display("FAIL skew_aw_first_ready: got %b expected 01", {awready, wready});
        end
        repeat (2) @(negedge clk);
        wdata = 32'hCAFE_0008; wstrb = 4'hF; wvalid = 1'b1;
        checks++;
        if (bvalid !== 1'b0) begin
            failures++; $display("FAIL skew_early_bvalid: got %b expected 0", bvalid);
        end
        @(negedge clk);
        wvalid = 1'b0;
        model_write(5'h08, 32'hCAFE_0008, 4'hF);
        checks++;
        if ({bvalid, bresp} !== 3'b100 || reg_out !== model_vec()) begin
            failures++;
            $display("FAIL skew_aw_first_b: got b=%b regout=%h expected 100 %h", {bvalid, bresp}, reg_out, model_vec());
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        // W leads AW by three cycles
        wdata = 32'hBEEF_000C; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        checks++;
        if ({awready, wready, bvalid} !== 3'b100) begin
            failures++; $display("FAIL skew_w_first_ready: got %b expected 100", {awready, wready, bvalid});
        end
        repeat (2) @(negedge clk);
        awaddr = 5'h0C; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        model_write(5'h0C, 32'hBEEF_000C, 4'hF);
        checks++;
        if ({bvalid, bresp} !== 3'b100) begin
            failures++; $display("FAIL skew_w_first_b: got %b expected 100", {bvalid, bresp});
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        axi_read(5'h0C, d, r, ok);
        checks++;
        if (!ok || d !== 32'hBEEF_000C || r !== 2'b00) begin
            failures++; $display("FAIL skew_readback: got %h resp=%b expected BEEF000C 00", d, r);
        end
    endtask

    task automatic test_back_to_back();
        // First write then B stalled 5 cycles while a second write waits.
        awaddr = 5'h00; wdata = 32'h1111_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        model_write(5'h00, 32'h1111_2222, 4'hF);
        wdata = 32'h3333_4444;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bvalid, bresp, awready, wready} !== 5'b10000 || reg_out !== model_vec()) begin
                failures++;
                $display("FAIL b2b_stall[%0d]: got ctrl=%b regout=%h expected 10000 %h",
                         i, {bvalid, bresp, awready, wready}, reg_out, model_vec());
            end
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        checks++;
        if ({bvalid, awready, wready} !== 3'b011 || reg_out !== model_vec()) begin
            failures++;
            $display("FAIL b2b_released: got ctrl=%b regout=%h expected 011 %h",
                     {bvalid, awready, wready}, reg_out, model_vec());
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(5'h00, 32'h3333_4444, 4'hF);
        checks++;
        if ({bvalid, bresp} !== 3'b100 || reg_out !== model_vec()) begin
            failures++;
            $display("FAIL b2b_second: got b=%b regout=%h expected 100 %h", {bvalid, bresp}, reg_out, model_vec());
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic test_read_hold();
        logic [31:0] exp_d;
        exp_d = model_read(5'h08);
        araddr = 5'h08; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rvalid, arready, rresp} !== 4'b1000 || rdata !== exp_d) begin
                failures++;
                $display("FAIL rhold[%0d]: got ctrl=%b data=%h expected 1000 %h", i, {rvalid, arready, rresp}, rdata, exp_d);
            end
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        checks++;
        if ({rvalid, arready} !== 2'b01) begin
            failures++; $display("FAIL rhold_release: got %b expected 01", {rvalid, arready});
        end
    endtask

    task automatic test_same_edge();
        logic [31:0] old_d;
        old_d = model_read(5'h04);
        awaddr = 5'h04; wdata = 32'h5A5A_0404; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'h04; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model_write(5'h04, 32'h5A5A_0404, 4'hF);
        checks++;
        if (rvalid !== 1'b1 || rdata !== old_d || bvalid !== 1'b1 || reg_out !== model_vec()) begin
            failures++;
            $display("FAIL same_edge: got rv=%b rdata=%h bv=%b regout=%h expected 1 %h 1 %h",
                     rvalid, rdata, bvalid, reg_out, old_d, model_vec());
        end
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [1:0]  r;
        logic [31:0] d;
        bit          ok;
        axi_write(5'h10, 32'hDEAD_BEEF, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 2'b10 || reg_out !== model_vec()) begin
            failures++;
            $display("FAIL oor_write: got resp=%b regout=%h expected 10 %h", r, reg_out, model_vec());
        end
        axi_read(5'h14, d, r, ok);
        checks++;
        if (!ok || r !== 2'b10 || d !== 32'h0) begin
            failures++; $display("FAIL oor_read: got data=%h resp=%b expected 0 10", d, r);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r;
        bit         ok;
        awaddr = 5'h08; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        checks++;
        if ({awready, wready} !== 2'b01) begin
            failures++; $display("FAIL rmid_pending: got %b expected 01", {awready, wready});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid} !== 4'b0000 || reg_out !== 128'h0) begin
            failures++;
            $display("FAIL rmid_in_reset: got %b regout=%h expected 0000 0", {awready, wready, arready, bvalid}, reg_out);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid} !== 4'b1110 || reg_out !== 128'h0) begin
            failures++;
            $display("FAIL rmid_release: got %b regout=%h expected 1110 0", {awready, wready, arready, bvalid}, reg_out);
        end
        axi_write(5'h08, 32'h0000_00A5, 4'hF, r, ok);
        model_write(5'h08, 32'h0000_00A5, 4'hF);
        checks++;
        if (!ok || r !== 2'b00 || reg_out !== model_vec()) begin
            failures++;
            $display("FAIL rmid_next_write: got ok=%0d resp=%b regout=%h expected 1 00 %h", ok, r, reg_out, model_vec());
        end
    endtask

    task automatic test_random();
        logic [4:0]  a;
        logic [31:0] d, got;
        logic [3:0]  s;
        logic [1:0]  r;
        bit          ok;
        for (int i = 0; i < 150; i++) begin
            a = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, r, ok);
                model_write(a, d, s);
                checks++;
                if (!ok || r !== exp_resp(a)) begin
                    failures++;
                    $display("FAIL rand_write[%0d] addr=%h: got ok=%0d resp=%b expected 1 %b", i, a, ok, r, exp_resp(a));
                end
            end else begin
                axi_read(a, got, r, ok);
                checks++;
                if (!ok || r !== exp_resp(a) || got !== model_read(a)) begin
                    failures++;
                    $display("FAIL rand_read[%0d] addr=%h: got data=%h resp=%b expected %h %b",
                             i, a, got, r, model_read(a), exp_resp(a));
                end
            end
            if (i % 16 == 15) begin
                checks++;
                if (reg_out !== model_vec()) begin
                    failures++; $display("FAIL rand_regout[%0d]: got %h expected %h", i, reg_out, model_vec());
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        awaddr = 5'h0; awprot = 3'b000; awvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
        araddr = 5'h0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_basic();
        test_strobe();
        test_skew();
        test_back_to_back();
        test_read_hold();
        test_same_edge();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
